core_sequencer: RTL and testbench

//  Multi-cycle successor to the single-cycle core decoder. It accepts one op_code per handshake
//  and drives the datapath control fields, holding them until memory completes. It also

---
 rtl/core_sequencer_if.sv | 56 +++++
 rtl/core_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_core_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/core_sequencer_if.sv
// ============================================================================
//  Module   : core_sequencer_if
//  Purpose  : Handshake and datapath-control bundle between the fetch unit,
//             the core sequencer and the acc/head/stack/cache datapath.
//  Ports    : instr/instr_valid/instr_ready  - instruction handshake
//             acc_zero                        - current cell is zero
//             mem_ready/mem_req/mem_we        - memory operation handshake
//             alu_op/acc_src/mem_src/mem_addr - datapath mux selects
//             *_write                         - register write-enable pulses
//             pc_step/pc_back                 - program counter stepping
//             scanning/nest_err               - bracket-scan and error status
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface core_sequencer_if #(
  parameter int OP_W = 4
);
  logic [OP_W-1:0] instr;
  logic            instr_valid;
  logic            instr_ready;
  logic            acc_zero;
  logic            mem_ready;
  logic            mem_req;
  logic            mem_we;
  logic            alu_op;
  logic            acc_src;
  logic [1:0]      mem_src;
  logic [1:0]      mem_addr;
  logic            acc_write;
  logic            stack_write;
  logic            head_write;
  logic            cache_write;
  logic            pc_step;
  logic            pc_back;
  logic            scanning;
  logic            nest_err;

  // Fetch/datapath side
  modport master (
    output instr, instr_valid, acc_zero, mem_ready,
    input  instr_ready, mem_req, mem_we, alu_op, acc_src, mem_src, mem_addr,
    input  acc_write, stack_write, head_write, cache_write,
    input  pc_step, pc_back, scanning, nest_err
  );

  // Sequencer side
  modport slave (
    input  instr, instr_valid, acc_zero, mem_ready,
    output instr_ready, mem_req, mem_we, alu_op, acc_src, mem_src, mem_addr,
    output acc_write, stack_write, head_write, cache_write,
    output pc_step, pc_back, scanning, nest_err
  );
endinterface

`default_nettype wire

// File: rtl/core_sequencer.sv
// ============================================================================
//  Module   : core_sequencer
//  Purpose  : Multi-cycle instruction sequencer. Accepts one op_code per
//             handshake, holds the datapath control fields until memory
//             completes, and resolves CBF/CBB loop brackets with a nesting
//             depth counter so the fetch unit only has to step the PC.
//  Ports    : clk    - rising-edge clock
//             rst_n  - asynchronous active-low reset
//             bus    - core_sequencer_if.slave (instruction handshake,
//                      memory handshake, datapath controls, status)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_sequencer #(
  parameter int OP_W    = 4,
  parameter int DEPTH_W = 8,
  parameter int MEM_TO  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  core_sequencer_if.slave    bus
);

  // Op-code encoding; anything else decodes as NOP
  localparam logic [OP_W-1:0] c_OP_INC = OP_W'(0);
  localparam logic [OP_W-1:0] c_OP_DEC = OP_W'(1);
  localparam logic [OP_W-1:0] c_OP_PSH = OP_W'(2);
  localparam logic [OP_W-1:0] c_OP_POP = OP_W'(3);
  localparam logic [OP_W-1:0] c_OP_MVR = OP_W'(4);
  localparam logic [OP_W-1:0] c_OP_MVL = OP_W'(5);
  localparam logic [OP_W-1:0] c_OP_CBF = OP_W'(6);
  localparam logic [OP_W-1:0] c_OP_CBB = OP_W'(7);

  // Timeout counter runs 0..MEM_TO-1; keep at least one bit when disabled
  localparam int               c_TO_W    = (MEM_TO > 1) ? $clog2(MEM_TO) : 1;
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(MEM_TO - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_SCAN_F = 2'd2,
    ST_SCAN_B = 2'd3
  } state_t;

  state_t              r_state;
  logic [DEPTH_W-1:0]  r_depth;
  logic [c_TO_W-1:0]   r_to;
  logic                r_err;
  logic                r_mem_req;
  logic                r_mem_we;
  logic                r_alu_op;
  logic                r_acc_src;
  logic [1:0]          r_mem_src;
  logic [1:0]          r_mem_addr;
  logic [3:0]          r_en;       // {cache, head, stack, acc}

  logic                w_ready;
  logic                w_accept;
  logic                w_is_cbf;
  logic                w_is_cbb;
  logic                w_is_mem_op;
  logic                w_we;
  logic                w_alu;
  logic                w_acc_src;
  logic [1:0]          w_mem_src;
  logic [1:0]          w_mem_addr;
  logic [3:0]          w_en;
  logic                w_depth_max;
  logic                w_depth_one;
  logic                w_to_hit;
  logic                w_done;
  logic                w_idle_acc;
  logic                w_scan_acc;

  assign w_ready     = (r_state != ST_EXEC) && !r_err;
  assign w_accept    = bus.instr_valid && w_ready;
  assign w_is_cbf    = (bus.instr == c_OP_CBF);
  assign w_is_cbb    = (bus.instr == c_OP_CBB);
  assign w_depth_max = &r_depth;
  assign w_depth_one = (r_depth == DEPTH_W'(1));
  assign w_to_hit    = (MEM_TO != 0) && (r_to == c_TO_LAST);
  assign w_done      = (r_state == ST_EXEC) && bus.mem_ready;
  assign w_idle_acc  = (r_state == ST_IDLE) && w_accept;
  assign w_scan_acc  = ((r_state == ST_SCAN_F) || (r_state == ST_SCAN_B)) && w_accept;

  // Datapath field decode for memory-touching ops
  always_comb begin
    w_is_mem_op = 1'b1;
    w_we        = 1'b0;
    w_alu       = 1'b0;
    w_acc_src   = 1'b0;
    w_mem_src   = 2'd0;
    w_mem_addr  = 2'd0;
    w_en        = 4'b0000;
    case (bus.instr)
      c_OP_INC: begin w_we = 1'b1; w_en = 4'b0001; end
      c_OP_DEC: begin w_we = 1'b1; w_alu = 1'b1; w_en = 4'b0001; end
      c_OP_PSH: begin w_we = 1'b1; w_mem_src = 2'd1; w_en = 4'b0010; end
      c_OP_POP: begin w_alu = 1'b1; w_acc_src = 1'b1; w_mem_addr = 2'd1; w_en = 4'b0011; end
      c_OP_MVR: begin w_acc_src = 1'b1; w_mem_addr = 2'd2; w_en = 4'b0101; end
      c_OP_MVL: begin w_alu = 1'b1; w_acc_src = 1'b1; w_mem_addr = 2'd2; w_en = 4'b0101; end
      default:  w_is_mem_op = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_depth    <= '0;
      r_to       <= '0;
      r_err      <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_alu_op   <= 1'b0;
      r_acc_src  <= 1'b0;
      r_mem_src  <= 2'd0;
      r_mem_addr <= 2'd0;
      r_en       <= 4'b0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_is_cbf) begin
              if (bus.acc_zero) begin
                r_state <= ST_SCAN_F;
                r_depth <= DEPTH_W'(1);
              end
            end else if (w_is_cbb) begin
              if (!bus.acc_zero) begin
                r_state <= ST_SCAN_B;
                r_depth <= DEPTH_W'(1);
              end
            end else if (w_is_mem_op) begin
              r_state    <= ST_EXEC;
              r_to       <= '0;
              r_mem_req  <= 1'b1;
              r_mem_we   <= w_we;
              r_alu_op   <= w_alu;
              r_acc_src  <= w_acc_src;
              r_mem_src  <= w_mem_src;
              r_mem_addr <= w_mem_addr;
              r_en       <= w_en;
            end
          end
        end

        ST_EXEC: begin
          if (bus.mem_ready || w_to_hit) begin
            // Completion and timeout both drop the held fields
            r_state    <= ST_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_alu_op   <= 1'b0;
            r_acc_src  <= 1'b0;
            r_mem_src  <= 2'd0;
            r_mem_addr <= 2'd0;
            r_en       <= 4'b0000;
            if (!bus.mem_ready) begin
              r_err <= 1'b1;
            end
          end else begin
            r_to <= r_to + 1'b1;
          end
        end

        ST_SCAN_F, ST_SCAN_B: begin
          if (w_accept) begin
            // Opening bracket for this scan direction nests deeper
            if ((r_state == ST_SCAN_F) ? w_is_cbf : w_is_cbb) begin
              if (w_depth_max) begin
                r_err   <= 1'b1;
                r_depth <= '0;
                r_state <= ST_IDLE;
              end else begin
                r_depth <= r_depth + 1'b1;
              end
            end else if ((r_state == ST_SCAN_F) ? w_is_cbb : w_is_cbf) begin
              r_depth <= r_depth - 1'b1;
              if (w_depth_one) begin
                r_state <= ST_IDLE;
              end
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Held controls come straight from registers; pulses are qualified by the
  // handshake of the current cycle so they land in the accept / mem_ready cycle.
  assign bus.instr_ready = w_ready;
  assign bus.mem_req     = r_mem_req;
  assign bus.mem_we      = r_mem_we;
  assign bus.alu_op      = r_alu_op;
  assign bus.acc_src     = r_acc_src;
  assign bus.mem_src     = r_mem_src;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.acc_write   = w_done && r_en[0];
  assign bus.stack_write = w_done && r_en[1];
  assign bus.head_write  = w_done && r_en[2];
  assign bus.cache_write = w_done && r_en[3];
  assign bus.scanning    = (r_state == ST_SCAN_F) || (r_state == ST_SCAN_B);
  assign bus.nest_err    = r_err;

  assign bus.pc_step = w_done || (w_idle_acc && !w_is_mem_op) || w_scan_acc;

  // Backward steps: entering a backward scan, and every backward-scan accept
  // except the one that closes the outermost bracket (that step goes forward).
  assign bus.pc_back = (w_idle_acc && w_is_cbb && !bus.acc_zero) ||
                       ((r_state == ST_SCAN_B) && w_accept && !(w_is_cbf && w_depth_one));

endmodule

`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none

module tb_core_sequencer;

  localparam int OP_W = 4;
  localparam logic [3:0] INC = 4'd0, DEC = 4'd1, PSH = 4'd2, POP = 4'd3;
  localparam logic [3:0] MVR = 4'd4, MVL = 4'd5, CBF = 4'd6, CBB = 4'd7, NOP = 4'hF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  // {mem_we, alu_op, acc_src, mem_src[1:0], mem_addr[1:0], cache, head, stack, acc}
  logic [3:0]  op_tab  [6] = '{INC, DEC, PSH, POP, MVR, MVL};
  logic [10:0] exp_tab [6] = '{
    11'b1_0_0_00_00_0001,   // INC
    11'b1_1_0_00_00_0001,   // DEC
    11'b1_0_0_01_00_0010,   // PSH
    11'b0_1_1_00_01_0011,   // POP
    11'b0_0_1_00_10_0101,   // MVR
    11'b0_1_1_00_10_0101    // MVL
  };

  core_sequencer_if #(.OP_W(OP_W)) bus ();

  core_sequencer #(
    .OP_W    (OP_W),
    .DEPTH_W (2),
    .MEM_TO  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] op, input logic v, input logic az, input logic mr);
    @(negedge clk);
    bus.instr       = op;
    bus.instr_valid = v;
    bus.acc_zero    = az;
    bus.mem_ready   = mr;
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    bus.instr = NOP; bus.instr_valid = 1'b0; bus.acc_zero = 1'b0; bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.instr = NOP; bus.instr_valid = 1'b0; bus.acc_zero = 1'b0; bus.mem_ready = 1'b0;
    @(negedge clk); #1;
    n_total++; if (bus.instr_ready !== 1'b1) $display("FAIL rst_instr_ready got=%b exp=1", bus.instr_ready); else n_pass++;
    n_total++; if (bus.mem_req !== 1'b0) $display("FAIL rst_mem_req got=%b exp=0", bus.mem_req); else n_pass++;
    n_total++; if (bus.scanning !== 1'b0) $display("FAIL rst_scanning got=%b exp=0", bus.scanning); else n_pass++;
    n_total++; if (bus.nest_err !== 1'b0) $display("FAIL rst_nest_err got=%b exp=0", bus.nest_err); else n_pass++;
    n_total++; if (bus.pc_step !== 1'b0) $display("FAIL rst_pc_step got=%b exp=0", bus.pc_step); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_exec;
    drive(INC, 1'b1, 1'b0, 1'b0);
    drive(NOP, 1'b0, 1'b0, 1'b0);
    n_total++; if (bus.mem_req !== 1'b1) $display("FAIL mid_exec_mem_req got=%b exp=1", bus.mem_req); else n_pass++;
    n_total++; if (bus.instr_ready !== 1'b0) $display("FAIL mid_exec_ready got=%b exp=0", bus.instr_ready); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (bus.mem_req !== 1'b0) $display("FAIL async_rst_mem_req got=%b exp=0", bus.mem_req); else n_pass++;
    n_total++; if (bus.mem_we !== 1'b0) $display("FAIL async_rst_mem_we got=%b exp=0", bus.mem_we); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    drive(NOP, 1'b0, 1'b0, 1'b0);
    n_total++; if (bus.instr_ready !== 1'b1) $display("FAIL post_rst_ready got=%b exp=1", bus.instr_ready); else n_pass++;
    n_total++; if (bus.mem_req !== 1'b0) $display("FAIL post_rst_mem_req got=%b exp=0", bus.mem_req); else n_pass++;
  endtask

  task automatic test_inc_delay;
    drive(INC, 1'b1, 1'b0, 1'b0);
    n_total++; if (bus.pc_step !== 1'b0) $display("FAIL inc_accept_pc_step got=%b exp=0", bus.pc_step); else n_pass++;
    // Instruction bus changes during the wait must not disturb held fields
    for (int i = 0; i < 3; i++) begin
      drive(MVR, 1'b0, 1'b0, 1'b0);
      n_total++; if ({bus.mem_req, bus.mem_we, bus.alu_op, bus.acc_src, bus.mem_src, bus.mem_addr} !== 8'b1_1_0_0_00_00)
        $display("FAIL inc_wait%0d_fields got=%b exp=11000000", i,
                 {bus.mem_req, bus.mem_we, bus.alu_op, bus.acc_src, bus.mem_src, bus.mem_addr}); else n_pass++;
      n_total++; if ({bus.acc_write, bus.pc_step} !== 2'b00)
        $display("FAIL inc_wait%0d_pulses got=%b exp=00", i, {bus.acc_write, bus.pc_step}); else n_pass++;
    end
    drive(NOP, 1'b0, 1'b0, 1'b1);
    n_total++; if ({bus.acc_write, bus.stack_write, bus.head_write, bus.cache_write} !== 4'b1000)
      $display("FAIL inc_done_we got=%b exp=1000", {bus.acc_write, bus.stack_write, bus.head_write, bus.cache_write}); else n_pass++;
    n_total++; if ({bus.pc_step, bus.pc_back} !== 2'b10)
      $display("FAIL inc_done_pc got=%b exp=10", {bus.pc_step, bus.pc_back}); else n_pass++;
    drive(NOP, 1'b0, 1'b0, 1'b0);
    n_total++; if ({bus.acc_write, bus.pc_step, bus.mem_req, bus.instr_ready} !== 4'b0001)
      $display("FAIL inc_after got=%b exp=0001", {bus.acc_write, bus.pc_step, bus.mem_req, bus.instr_ready}); else n_pass++;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++) begin
      drive(op_tab[i], 1'b1, 1'b0, 1'b1);
      drive(NOP, 1'b0, 1'b0, 1'b1);
      n_total++; if ({bus.mem_we, bus.alu_op, bus.acc_src, bus.mem_src, bus.mem_addr,
                      bus.cache_write, bus.head_write, bus.stack_write, bus.acc_write} !== exp_tab[i])
        $display("FAIL op%0d_fields got=%b exp=%b", i,
                 {bus.mem_we, bus.alu_op, bus.acc_src, bus.mem_src, bus.mem_addr,
                  bus.cache_write, bus.head_write, bus.stack_write, bus.acc_write}, exp_tab[i]); else n_pass++;
      n_total++; if ({bus.mem_req, bus.pc_step} !== 2'b11)
        $display("FAIL op%0d_req_step got=%b exp=11", i, {bus.mem_req, bus.pc_step}); else n_pass++;
    end
  endtask

  task automatic test_idle_skip;
    drive(CBF, 1'b1, 1'b0, 1'b0);
    n_total++; if ({bus.pc_step, bus.pc_back} !== 2'b10) $display("FAIL cbf_nz_pc got=%b exp=10", {bus.pc_step, bus.pc_back}); else n_pass++;
    drive(CBB, 1'b1, 1'b1, 1'b0);
    n_total++; if ({bus.pc_step, bus.pc_back, bus.scanning} !== 3'b100)
      $display("FAIL cbb_z_pc got=%b exp=100", {bus.pc_step, bus.pc_back, bus.scanning}); else n_pass++;
    drive(NOP, 1'b1, 1'b0, 1'b0);
    n_total++; if ({bus.pc_step, bus.scanning} !== 2'b10) $display("FAIL nop_pc got=%b exp=10", {bus.pc_step, bus.scanning}); else n_pass++;
    drive(NOP, 1'b0, 1'b0, 1'b0);
    n_total++; if ({bus.pc_step, bus.scanning, bus.mem_req} !== 3'b000)
      $display("FAIL skip_after got=%b exp=000", {bus.pc_step, bus.scanning, bus.mem_req}); else n_pass++;
  endtask

  task automatic test_scan_fwd;
    logic [3:0] stream [4] = '{CBF, INC, CBB, CBB};
    int steps = 0;
    drive(CBF, 1'b1, 1'b1, 1'b0);
    if (bus.pc_step === 1'b1) steps++;
    n_total++; if (bus.pc_back !== 1'b0) $display("FAIL sf_entry_back got=%b exp=0", bus.pc_back); else n_pass++;
    drive(NOP, 1'b0, 1'b0, 1'b0);
    n_total++; if ({bus.scanning, bus.pc_step} !== 2'b10) $display("FAIL sf_idle got=%b exp=10", {bus.scanning, bus.pc_step}); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      drive(stream[i], 1'b1, 1'b0, 1'b1);
      if (bus.pc_step === 1'b1) steps++;
      n_total++; if ({bus.scanning, bus.instr_ready, bus.pc_step, bus.pc_back, bus.mem_req, bus.acc_write} !== 6'b111000)
        $display("FAIL sf_acc%0d got=%b exp=111000", i,
                 {bus.scanning, bus.instr_ready, bus.pc_step, bus.pc_back, bus.mem_req, bus.acc_write}); else n_pass++;
    end
    drive(NOP, 1'b0, 1'b0, 1'b0);
    n_total++; if (bus.scanning !== 1'b0) $display("FAIL sf_exit got=%b exp=0", bus.scanning); else n_pass++;
    n_total++; if (steps !== 5) $display("FAIL sf_steps got=%0d exp=5", steps); else n_pass++;
  endtask

  task automatic test_scan_bwd;
    logic [3:0] stream [4] = '{INC, CBB, CBF, CBF};
    logic       back   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    drive(CBB, 1'b1, 1'b0, 1'b0);
    n_total++; if ({bus.pc_step, bus.pc_back} !== 2'b11) $display("FAIL sb_entry got=%b exp=11", {bus.pc_step, bus.pc_back}); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      drive(stream[i], 1'b1, 1'b1, 1'b0);
      n_total++; if ({bus.scanning, bus.pc_step, bus.pc_back} !== {1'b1, 1'b1, back[i]})
        $display("FAIL sb_acc%0d got=%b exp=%b", i, {bus.scanning, bus.pc_step, bus.pc_back}, {1'b1, 1'b1, back[i]}); else n_pass++;
    end
    drive(NOP, 1'b0, 1'b0, 1'b0);
    n_total++; if ({bus.scanning, bus.pc_step} !== 2'b00) $display("FAIL sb_exit got=%b exp=00", {bus.scanning, bus.pc_step}); else n_pass++;
  endtask

  task automatic test_overflow;
    do_reset();
    drive(CBF, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(CBF, 1'b1, 1'b0, 1'b0);
      n_total++; if (bus.nest_err !== 1'b0) $display("FAIL ovf_early%0d got=%b exp=0", i, bus.nest_err); else n_pass++;
    end
    drive(CBF, 1'b1, 1'b0, 1'b0);
    drive(NOP, 1'b0, 1'b0, 1'b0);
    n_total++; if ({bus.nest_err, bus.instr_ready, bus.scanning} !== 3'b100)
      $display("FAIL ovf_err got=%b exp=100", {bus.nest_err, bus.instr_ready, bus.scanning}); else n_pass++;
    drive(INC, 1'b1, 1'b0, 1'b1);
    n_total++; if ({bus.instr_ready, bus.pc_step} !== 2'b00) $display("FAIL ovf_halt got=%b exp=00", {bus.instr_ready, bus.pc_step}); else n_pass++;
    drive(NOP, 1'b0, 1'b0, 1'b1);
    n_total++; if ({bus.mem_req, bus.acc_write, bus.nest_err} !== 3'b001)
      $display("FAIL ovf_sticky got=%b exp=001", {bus.mem_req, bus.acc_write, bus.nest_err}); else n_pass++;
  endtask

  task automatic test_timeout;
    do_reset();
    drive(POP, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(NOP, 1'b0, 1'b0, 1'b0);
      n_total++; if ({bus.mem_req, bus.nest_err, bus.acc_write, bus.stack_write} !== 4'b1000)
        $display("FAIL to_wait%0d got=%b exp=1000", i, {bus.mem_req, bus.nest_err, bus.acc_write, bus.stack_write}); else n_pass++;
    end
    drive(NOP, 1'b0, 1'b0, 1'b0);
    n_total++; if ({bus.nest_err, bus.mem_req, bus.instr_ready} !== 3'b100)
      $display("FAIL to_err got=%b exp=100", {bus.nest_err, bus.mem_req, bus.instr_ready}); else n_pass++;
    drive(NOP, 1'b0, 1'b0, 1'b1);
    n_total++; if ({bus.acc_write, bus.stack_write, bus.pc_step} !== 3'b000)
      $display("FAIL to_late_ready got=%b exp=000", {bus.acc_write, bus.stack_write, bus.pc_step}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_reset_mid_exec();
    test_inc_delay();
    test_back_to_back();
    test_idle_skip();
    test_scan_fwd();
    test_scan_bwd();
    test_overflow();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
